// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the PIM MAC slave.
package axi_pkg;

   typedef enum logic [1:0] {
      BurstFixed = 2'd0,
      BurstIncr  = 2'd1,
      BurstWrap  = 2'd2
   } burst_e;

   localparam logic [1:0] RespOkay = 2'b00;

   typedef enum logic {WrIdle, WrBurst} wr_state_e;
   typedef enum logic {RdIdle, RdBurst} rd_state_e;

endpackage

// File: rtl/pim_mac.sv
// Wrapping multiply-accumulate of the two unsigned halves of each enabled data word.
module pim_mac #(
   parameter int unsigned PWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [PWIDTH-1:0] data,
   output logic [PWIDTH-1:0] acc
);

   localparam int unsigned Half = PWIDTH / 2;

   logic [PWIDTH-1:0] prod;

   // Zero-extend both halves so the product truncates to PWIDTH bits.
   assign prod = {{Half{1'b0}}, data[Half-1:0]} * {{Half{1'b0}}, data[PWIDTH-1:Half]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod;
      end
   end

endmodule

// File: rtl/axi_pim_mac.sv
// Word-organised AXI4 RAM slave; every accepted write beat also feeds a MAC accumulator.
module axi_pim_mac
   import axi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH      = 8,
   parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH        = 8,
   parameter int unsigned PIPELINE_OUTPUT = 0,
   parameter int unsigned PWIDTH          = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_WIDTH-1:0]   s_axi_awid,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [7:0]            s_axi_awlen,
   input  logic [2:0]            s_axi_awsize,
   input  logic [1:0]            s_axi_awburst,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
   input  logic                  s_axi_wlast,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [ID_WIDTH-1:0]   s_axi_bid,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ID_WIDTH-1:0]   s_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic [2:0]            s_axi_arsize,
   input  logic [1:0]            s_axi_arburst,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [ID_WIDTH-1:0]   s_axi_rid,
   output logic [DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [PWIDTH-1:0]     mac_out
);

   localparam int unsigned WordLsb = $clog2(STRB_WIDTH);
   localparam int unsigned Depth   = 1 << (ADDR_WIDTH - WordLsb);

   logic [DATA_WIDTH-1:0] mem [Depth];

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
      if (burst == BurstFixed) return a;
      return a + ADDR_WIDTH'(1 << size);
   endfunction

   // Holds both address channels off until the first edge after reset.
   logic rdy_q;

   wr_state_e             wr_state_q, wr_state_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]            wr_cnt_q, wr_cnt_d;
   logic [2:0]            wr_size_q, wr_size_d;
   logic [1:0]            wr_burst_q, wr_burst_d;
   logic [ID_WIDTH-1:0]   wr_id_q, wr_id_d;
   logic                  bvalid_q, bvalid_d;
   logic [ID_WIDTH-1:0]   bid_q, bid_d;
   logic                  aw_hs, w_hs;
   logic                  unused_wlast;

   assign unused_wlast  = s_axi_wlast;
   assign aw_hs         = s_axi_awvalid && s_axi_awready;
   assign w_hs          = s_axi_wvalid && s_axi_wready;
   assign s_axi_awready = rdy_q && (wr_state_q == WrIdle) && (!bvalid_q || s_axi_bready);
   assign s_axi_wready  = (wr_state_q == WrBurst);
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bid     = bid_q;
   assign s_axi_bresp   = RespOkay;

   always_comb begin
      wr_state_d = wr_state_q;
      wr_addr_d  = wr_addr_q;
      wr_cnt_d   = wr_cnt_q;
      wr_size_d  = wr_size_q;
      wr_burst_d = wr_burst_q;
      wr_id_d    = wr_id_q;
      bvalid_d   = bvalid_q && !s_axi_bready;
      bid_d      = bid_q;
      unique case (wr_state_q)
         WrIdle: begin
            if (aw_hs) begin
               wr_addr_d  = s_axi_awaddr;
               wr_cnt_d   = s_axi_awlen;
               wr_size_d  = s_axi_awsize;
               wr_burst_d = s_axi_awburst;
               wr_id_d    = s_axi_awid;
               wr_state_d = WrBurst;
            end
         end
         WrBurst: begin
            if (w_hs) begin
               wr_addr_d = next_addr(wr_addr_q, wr_size_q, wr_burst_q);
               wr_cnt_d  = wr_cnt_q - 8'd1;
               // Beat count alone ends the burst; wlast is not trusted.
               if (wr_cnt_q == 8'd0) begin
                  wr_state_d = WrIdle;
                  bvalid_d   = 1'b1;
                  bid_d      = wr_id_q;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(STRB_WIDTH); i++) begin
         if (w_hs && s_axi_wstrb[i]) begin
            mem[wr_addr_q[ADDR_WIDTH-1:WordLsb]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
         end
      end
   end

   rd_state_e             rd_state_q, rd_state_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [7:0]            rd_cnt_q, rd_cnt_d;
   logic [2:0]            rd_size_q, rd_size_d;
   logic [1:0]            rd_burst_q, rd_burst_d;
   logic [ID_WIDTH-1:0]   rd_id_q, rd_id_d;
   logic                  r0_valid_q, r0_valid_d;
   logic                  r0_last_q, r0_last_d;
   logic [ID_WIDTH-1:0]   r0_id_q, r0_id_d;
   logic [DATA_WIDTH-1:0] r0_data_q;
   logic                  r1_valid_q, r1_last_q;
   logic [ID_WIDTH-1:0]   r1_id_q;
   logic [DATA_WIDTH-1:0] r1_data_q;
   logic                  ar_hs, out_ready, r0_ready, r1_adv, rd_fetch;
   logic [ADDR_WIDTH-1:0] fetch_addr;

   assign ar_hs     = s_axi_arvalid && s_axi_arready;
   assign r1_adv    = (PIPELINE_OUTPUT != 0) && (!r1_valid_q || s_axi_rready);
   assign out_ready = (PIPELINE_OUTPUT != 0) ? r1_adv : s_axi_rready;
   assign r0_ready  = !r0_valid_q || out_ready;
   // A new request waits until the previous burst has fully drained.
   assign s_axi_arready = rdy_q && (rd_state_q == RdIdle) && !r0_valid_q && !r1_valid_q;

   always_comb begin
      rd_state_d = rd_state_q;
      rd_addr_d  = rd_addr_q;
      rd_cnt_d   = rd_cnt_q;
      rd_size_d  = rd_size_q;
      rd_burst_d = rd_burst_q;
      rd_id_d    = rd_id_q;
      r0_valid_d = r0_valid_q && !out_ready;
      r0_last_d  = r0_last_q;
      r0_id_d    = r0_id_q;
      rd_fetch   = 1'b0;
      fetch_addr = rd_addr_q;
      unique case (rd_state_q)
         RdIdle: begin
            if (ar_hs) begin
               rd_fetch   = 1'b1;
               fetch_addr = s_axi_araddr;
               r0_last_d  = (s_axi_arlen == 8'd0);
               r0_id_d    = s_axi_arid;
               rd_id_d    = s_axi_arid;
               rd_size_d  = s_axi_arsize;
               rd_burst_d = s_axi_arburst;
               rd_addr_d  = next_addr(s_axi_araddr, s_axi_arsize, s_axi_arburst);
               rd_cnt_d   = s_axi_arlen;
               if (s_axi_arlen != 8'd0) rd_state_d = RdBurst;
            end
         end
         RdBurst: begin
            if (r0_ready) begin
               rd_fetch  = 1'b1;
               r0_last_d = (rd_cnt_q == 8'd1);
               r0_id_d   = rd_id_q;
               rd_addr_d = next_addr(rd_addr_q, rd_size_q, rd_burst_q);
               rd_cnt_d  = rd_cnt_q - 8'd1;
               if (rd_cnt_q == 8'd1) rd_state_d = RdIdle;
            end
         end
      endcase
      if (rd_fetch) r0_valid_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q      <= 1'b0;
         wr_state_q <= WrIdle;
         wr_addr_q  <= '0;
         wr_cnt_q   <= '0;
         wr_size_q  <= '0;
         wr_burst_q <= '0;
         wr_id_q    <= '0;
         bvalid_q   <= 1'b0;
         bid_q      <= '0;
         rd_state_q <= RdIdle;
         rd_addr_q  <= '0;
         rd_cnt_q   <= '0;
         rd_size_q  <= '0;
         rd_burst_q <= '0;
         rd_id_q    <= '0;
         r0_valid_q <= 1'b0;
         r0_last_q  <= 1'b0;
         r0_id_q    <= '0;
         r0_data_q  <= '0;
         r1_valid_q <= 1'b0;
         r1_last_q  <= 1'b0;
         r1_id_q    <= '0;
         r1_data_q  <= '0;
      end else begin
         rdy_q      <= 1'b1;
         wr_state_q <= wr_state_d;
         wr_addr_q  <= wr_addr_d;
         wr_cnt_q   <= wr_cnt_d;
         wr_size_q  <= wr_size_d;
         wr_burst_q <= wr_burst_d;
         wr_id_q    <= wr_id_d;
         bvalid_q   <= bvalid_d;
         bid_q      <= bid_d;
         rd_state_q <= rd_state_d;
         rd_addr_q  <= rd_addr_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_size_q  <= rd_size_d;
         rd_burst_q <= rd_burst_d;
         rd_id_q    <= rd_id_d;
         r0_valid_q <= r0_valid_d;
         r0_last_q  <= r0_last_d;
         r0_id_q    <= r0_id_d;
         // Memory is sampled before this edge's write lands, so collisions read old data.
         if (rd_fetch) r0_data_q <= mem[fetch_addr[ADDR_WIDTH-1:WordLsb]];
         if (r1_adv) begin
            r1_valid_q <= r0_valid_q;
            if (r0_valid_q) begin
               r1_last_q <= r0_last_q;
               r1_id_q   <= r0_id_q;
               r1_data_q <= r0_data_q;
            end
         end
      end
   end

   assign s_axi_rvalid = (PIPELINE_OUTPUT != 0) ? r1_valid_q : r0_valid_q;
   assign s_axi_rlast  = (PIPELINE_OUTPUT != 0) ? r1_last_q  : r0_last_q;
   assign s_axi_rid    = (PIPELINE_OUTPUT != 0) ? r1_id_q    : r0_id_q;
   assign s_axi_rdata  = (PIPELINE_OUTPUT != 0) ? r1_data_q  : r0_data_q;
   assign s_axi_rresp  = RespOkay;

   pim_mac #(
      .PWIDTH(PWIDTH)
   ) u_pim_mac (
      .clk (clk),
      .rst (rst),
      .en  (w_hs),
      .data(s_axi_wdata[PWIDTH-1:0]),
      .acc (mac_out)
   );

endmodule

// File: tb/tb_axi_pim_mac.sv
// Self-checking bench for axi_pim_mac: vector table, directed corner cases, random traffic.
module tb_axi_pim_mac;

   logic        clk, rst;
   logic [7:0]  awid, awaddr, awlen, arid, araddr, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [31:0] wdata, rdata, mac_out;
   logic [3:0]  wstrb;
   logic [7:0]  bid, rid;
   logic [1:0]  bresp, rresp;
   logic        arvalid, arready, rlast, rvalid, rready;

   axi_pim_mac #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .STRB_WIDTH(4), .ID_WIDTH(8),
      .PIPELINE_OUTPUT(0), .PWIDTH(32)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
      .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
      .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
      .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
      .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
      .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
      .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready), .mac_out(mac_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: 64-word memory image and the running accumulator.
   logic [31:0] mdl_mem [64];
   logic [31:0] mdl_acc;
   logic [31:0] wd [64];
   logic [3:0]  ws [64];
   logic [31:0] rd_got [64];

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      logic [31:0] exp_mac;
   } vec_t;
   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic sig(input int s);
      case (s)
         0: return awready;
         1: return wready;
         2: return bvalid;
         3: return arready;
         default: return rvalid;
      endcase
   endfunction

   // Polls at falling edges; caller is positioned at a falling edge.
   task automatic wait_hi(input int s, input string name);
      int n = 0;
      while (!sig(s) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!sig(s)) begin
         checks++;
         failures++;
         $display("FAIL timeout_%s: got 0 expected 1", name);
      end
   endtask

   function automatic logic [7:0] beat_addr(input logic [7:0] a, input logic [1:0] burst, input int k);
      return (burst == 2'd0) ? a : 8'(int'(a) + 4 * k);
   endfunction

   task automatic axi_write(input logic [7:0] id, input logic [7:0] addr, input int len,
                            input logic [1:0] burst, input int bhold);
      logic [7:0] ea;
      awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'd2; awburst = burst; awvalid = 1'b1;
      wait_hi(0, "awready");
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0;
      for (int k = 0; k <= len; k++) begin
         wdata = wd[k]; wstrb = ws[k]; wlast = (k == len); wvalid = 1'b1;
         wait_hi(1, "wready");
         @(posedge clk);
         ea = beat_addr(addr, burst, k);
         for (int b = 0; b < 4; b++)
            if (ws[k][b]) mdl_mem[ea[7:2]][8*b +: 8] = wd[k][8*b +: 8];
         mdl_acc = mdl_acc + wd[k][15:0] * wd[k][31:16];
         @(negedge clk);
      end
      wvalid = 1'b0;
      wlast = 1'b0;
      check("wready_after_last", wready, 0);
      wait_hi(2, "bvalid");
      check("bid", bid, id);
      check("bresp", bresp, 0);
      for (int c = 0; c < bhold; c++) begin
         check("bvalid_held", bvalid, 1);
         check("awready_blocked", awready, 0);
         @(posedge clk);
         @(negedge clk);
      end
      bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bready = 1'b0;
      check("bvalid_clr", bvalid, 0);
      check("mac_out", mac_out, mdl_acc);
   endtask

   task automatic axi_read(input logic [7:0] id, input logic [7:0] addr, input int len,
                           input logic [1:0] burst, input int stall_beat, input int stall_cyc);
      logic [7:0] ea;
      arid = id; araddr = addr; arlen = 8'(len); arsize = 3'd2; arburst = burst; arvalid = 1'b1;
      wait_hi(3, "arready");
      @(posedge clk);
      @(negedge clk);
      arvalid = 1'b0;
      for (int k = 0; k <= len; k++) begin
         wait_hi(4, "rvalid");
         ea = beat_addr(addr, burst, k);
         rd_got[k] = rdata;
         check("rdata_model", rdata, mdl_mem[ea[7:2]]);
         check("rid", rid, id);
         check("rresp", rresp, 0);
         check("rlast", rlast, (k == len));
         if (k == stall_beat) begin
            for (int c = 0; c < stall_cyc; c++) begin
               @(posedge clk);
               @(negedge clk);
               check("rvalid_stall", rvalid, 1);
               check("rdata_stall", rdata, rd_got[k]);
            end
         end
         rready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         rready = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h10, 32'h0003_0002, 4'hF, 32'h0003_0002, 32'h0000_0006};
      vecs[1] = '{8'h14, 32'h0005_0004, 4'hF, 32'h0005_0004, 32'h0000_001A};
      vecs[2] = '{8'h10, 32'h00AA_0000, 4'h4, 32'h00AA_0002, 32'h0000_001A};
      vecs[3] = '{8'h18, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF, 32'hFFFE_001B};
      vecs[4] = '{8'h1B, 32'h0001_0003, 4'h3, 32'hFFFF_0003, 32'hFFFE_001E};
      vecs[5] = '{8'hFC, 32'h0010_0010, 4'hF, 32'h0010_0010, 32'hFFFE_011E};
      vecs[6] = '{8'h00, 32'h0002_0001, 4'hF, 32'h0002_0001, 32'hFFFE_0120};

      rst = 1'b0;
      {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
      {wdata, wstrb, wlast, wvalid, bready} = '0;
      {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
      mdl_acc = '0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_arready", arready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rlast", rlast, 0);
      check("rst_bid", bid, 0);
      check("rst_rid", rid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_mac", mac_out, 0);
      rst = 1'b0;
      #1 check("awready_pre_edge", awready, 0);
      @(negedge clk);
      check("awready_up", awready, 1);
      check("arready_up", arready, 1);

      // Fill the whole memory with one 64-beat burst so the model is fully known.
      for (int k = 0; k < 64; k++) begin
         wd[k] = $urandom;
         ws[k] = 4'hF;
      end
      axi_write(8'h01, 8'h00, 63, 2'd1, 0);
      axi_read(8'h02, 8'h00, 63, 2'd1, -1, 0);

      #2 rst = 1'b1;
      #1 rst = 1'b0;
      mdl_acc = '0;
      @(negedge clk);
      check("mac_cleared", mac_out, 0);

      for (int i = 0; i < 7; i++) begin
         wd[0] = vecs[i].wdata;
         ws[0] = vecs[i].strb;
         axi_write(8'(i + 16), vecs[i].addr, 0, 2'd1, 0);
         check("vec_mac", mac_out, vecs[i].exp_mac);
         axi_read(8'(i + 32), vecs[i].addr, 0, 2'd1, -1, 0);
         check("vec_rdata", rd_got[0], vecs[i].exp_rd);
      end

      wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
      axi_write(8'h3C, 8'h10, 0, 2'd1, 0);
      axi_read(8'h4D, 8'h10, 0, 2'd1, -1, 0);
      check("single_rdata", rd_got[0], 32'hDEAD_BEEF);
      check("rvalid_dropped", rvalid, 0);
      repeat (3) @(negedge clk);
      check("rdata_hold", rdata, 32'hDEAD_BEEF);

      wd[0] = 32'h1122_3344; ws[0] = 4'hF;
      axi_write(8'h05, 8'h20, 0, 2'd1, 0);
      wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
      axi_write(8'h06, 8'h20, 0, 2'd1, 0);
      axi_read(8'h07, 8'h20, 0, 2'd1, -1, 0);
      check("strobe_merge", rd_got[0], 32'h11BB_33DD);

      for (int k = 0; k < 4; k++) begin
         wd[k] = 32'(k + 1);
         ws[k] = 4'hF;
      end
      axi_write(8'h08, 8'h00, 3, 2'd1, 0);
      axi_read(8'h09, 8'h00, 3, 2'd1, -1, 0);
      for (int k = 0; k < 4; k++) check("incr_beat", rd_got[k], 32'(k + 1));
      axi_read(8'h0A, 8'h04, 3, 2'd0, -1, 0);
      for (int k = 0; k < 4; k++) check("fixed_beat", rd_got[k], 32'd2);
      axi_read(8'h0B, 8'h00, 3, 2'd1, 1, 4);
      check("stall_beat2", rd_got[1], 32'd2);

      wd[0] = 32'h0001_0001; ws[0] = 4'hF;
      axi_write(8'h0C, 8'h30, 0, 2'd1, 3);

      // Overlapping write and read bursts, interrupted by an asynchronous reset.
      awid = 8'h5A; awaddr = 8'h40; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
      arid = 8'hA5; araddr = 8'h00; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
      check("g_awready", awready, 1);
      check("g_arready", arready, 1);
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0; arvalid = 1'b0;
      wdata = 32'h0002_0003; wstrb = 4'hF; wvalid = 1'b1;
      check("g_wready", wready, 1);
      @(posedge clk);
      mdl_mem[16] = 32'h0002_0003;
      mdl_acc = mdl_acc + 32'd6;
      @(negedge clk);
      wvalid = 1'b0;
      check("g_rvalid_pre", rvalid, 1);
      check("g_mac_pre", mac_out, mdl_acc);
      #1 rst = 1'b1;
      #1;
      check("g_rvalid", rvalid, 0);
      check("g_bvalid", bvalid, 0);
      check("g_wready_rst", wready, 0);
      check("g_rlast", rlast, 0);
      check("g_mac", mac_out, 0);
      #1 rst = 1'b0;
      mdl_acc = '0;
      @(negedge clk);
      wd[0] = 32'h0004_0003; wd[1] = 32'h0001_0002; ws[0] = 4'hF; ws[1] = 4'hF;
      axi_write(8'h11, 8'h40, 1, 2'd1, 0);
      check("post_rst_mac", mac_out, 32'd14);
      axi_read(8'h12, 8'h3C, 3, 2'd1, -1, 0);
      check("post_rst_rd", rd_got[1], 32'h0004_0003);

      for (int it = 0; it < 40; it++) begin
         logic [7:0] id, addr;
         int len;
         logic [1:0] burst;
         id = 8'($urandom);
         addr = 8'($urandom);
         len = $urandom_range(0, 7);
         burst = 2'($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k <= len; k++) begin
               wd[k] = $urandom;
               ws[k] = 4'($urandom);
            end
            axi_write(id, addr, len, burst, $urandom_range(0, 2));
         end else begin
            axi_read(id, addr, len, burst,
                     ($urandom_range(0, 1) == 1) ? $urandom_range(0, len) : -1,
                     $urandom_range(1, 3));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
